// File: rtl/invader_hit_tracker.sv
// Alive/dead tracker for the 3-row invader grid; scans one column per cycle.
// Optional score accumulator enabled by defining INVADER_SCORE_EN.
module invader_hit_tracker #(
    parameter int NUM_INVADERS   = 10,
    parameter int OFFSET         = 100,
    parameter int X_INIT         = 0,
    parameter int Y_ROW1         = 100,
    parameter int Y_ROW2         = 200,
    parameter int Y_ROW3         = 300,
    parameter int INVADER_WIDTH  = 64,
    parameter int INVADER_HEIGHT = 32
) (
    input  logic                    clk65MHz,
    input  logic                    rst_n,
    input  logic [9:0]              xpos,
    input  logic [9:0]              ypos,
    input  logic                    bullet_valid,
    output logic                    bullet_ready,
    input  logic [10:0]             bullet_x,
    input  logic [10:0]             bullet_y,
    input  logic                    new_wave,
    output logic [NUM_INVADERS-1:0] enable_row1,
    output logic [NUM_INVADERS-1:0] enable_row2,
    output logic [NUM_INVADERS-1:0] enable_row3,
    output logic                    hit_valid,
    output logic                    hit,
    output logic [1:0]              hit_row,
    output logic [3:0]              hit_col,
    output logic [4:0]              alive_count,
    output logic                    wave_clear,
    output logic [15:0]             score
);

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    localparam logic [4:0] MAX_ALIVE = 5'(3 * NUM_INVADERS);
    localparam logic [3:0] LAST_COL  = 4'(NUM_INVADERS - 1);
    localparam logic [NUM_INVADERS-1:0] ALL_ON = '1;

    state_t state_q, state_d;
    logic [11:0] bx_q, bx_d, by_q, by_d, x_acc_q, x_acc_d;
    logic [9:0]  ypos_q, ypos_d;
    logic [3:0]  col_q, col_d, hit_col_q, hit_col_d;
    logic [1:0]  hit_row_q, hit_row_d;
    logic [NUM_INVADERS-1:0] alive1_q, alive1_d;
    logic [NUM_INVADERS-1:0] alive2_q, alive2_d;
    logic [NUM_INVADERS-1:0] alive3_q, alive3_d;
    logic [4:0]  count_q, count_d;
    logic        hit_q, hit_d, hit_valid_q, hit_valid_d;
    logic        wave_clear_q, wave_clear_d;
    logic        x_in, m1, m2, m3, any_m, last;
    logic [11:0] top1, top2, top3;

    // Hit-box tests in 12-bit unsigned space; operands cannot overflow
    always_comb begin
        top1  = 12'(Y_ROW1) + {2'b00, ypos_q};
        top2  = 12'(Y_ROW2) + {2'b00, ypos_q};
        top3  = 12'(Y_ROW3) + {2'b00, ypos_q};
        x_in  = (bx_q >= x_acc_q) &&
                (bx_q < x_acc_q + 12'(INVADER_WIDTH));
        m1    = alive1_q[col_q] && x_in && (by_q >= top1) &&
                (by_q < top1 + 12'(INVADER_HEIGHT));
        m2    = alive2_q[col_q] && x_in && (by_q >= top2) &&
                (by_q < top2 + 12'(INVADER_HEIGHT));
        m3    = alive3_q[col_q] && x_in && (by_q >= top3) &&
                (by_q < top3 + 12'(INVADER_HEIGHT));
        any_m = m1 || m2 || m3;
        last  = (col_q == LAST_COL);
    end

    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (new_wave) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (bullet_valid) state_d = SCAN;
                SCAN:    if (any_m || last) state_d = RESP;
                RESP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bullet_ready = (state_q == IDLE);
    end

    always_comb begin
        bx_d         = bx_q;
        by_d         = by_q;
        ypos_d       = ypos_q;
        x_acc_d      = x_acc_q;
        col_d        = col_q;
        alive1_d     = alive1_q;
        alive2_d     = alive2_q;
        alive3_d     = alive3_q;
        count_d      = count_q;
        hit_d        = hit_q;
        hit_row_d    = hit_row_q;
        hit_col_d    = hit_col_q;
        hit_valid_d  = 1'b0;
        wave_clear_d = 1'b0;
        if (new_wave) begin
            alive1_d = ALL_ON;
            alive2_d = ALL_ON;
            alive3_d = ALL_ON;
            count_d  = MAX_ALIVE;
        end else begin
            unique case (state_q)
                IDLE: if (bullet_valid) begin
                    bx_d    = {1'b0, bullet_x};
                    by_d    = {1'b0, bullet_y};
                    ypos_d  = ypos;
                    col_d   = 4'd0;
                    x_acc_d = 12'(X_INIT) + {2'b00, xpos};
                end
                SCAN: begin
                    // Row 3 is nearest the player, so it takes priority
                    if (m3) begin
                        alive3_d[col_q] = 1'b0;
                        hit_row_d       = 2'd3;
                    end else if (m2) begin
                        alive2_d[col_q] = 1'b0;
                        hit_row_d       = 2'd2;
                    end else if (m1) begin
                        alive1_d[col_q] = 1'b0;
                        hit_row_d       = 2'd1;
                    end
                    if (any_m) begin
                        count_d   = count_q - 5'd1;
                        hit_d     = 1'b1;
                        hit_col_d = col_q;
                    end else if (last) begin
                        hit_d     = 1'b0;
                        hit_row_d = 2'd0;
                        hit_col_d = 4'd0;
                    end else begin
                        col_d   = col_q + 4'd1;
                        x_acc_d = x_acc_q + 12'(OFFSET);
                    end
                end
                RESP: begin
                    hit_valid_d  = 1'b1;
                    wave_clear_d = hit_q && (count_q == 5'd0);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) begin
            bx_q         <= '0;
            by_q         <= '0;
            ypos_q       <= '0;
            x_acc_q      <= '0;
            col_q        <= '0;
            alive1_q     <= ALL_ON;
            alive2_q     <= ALL_ON;
            alive3_q     <= ALL_ON;
            count_q      <= MAX_ALIVE;
            hit_q        <= 1'b0;
            hit_row_q    <= '0;
            hit_col_q    <= '0;
            hit_valid_q  <= 1'b0;
            wave_clear_q <= 1'b0;
        end else begin
            bx_q         <= bx_d;
            by_q         <= by_d;
            ypos_q       <= ypos_d;
            x_acc_q      <= x_acc_d;
            col_q        <= col_d;
            alive1_q     <= alive1_d;
            alive2_q     <= alive2_d;
            alive3_q     <= alive3_d;
            count_q      <= count_d;
            hit_q        <= hit_d;
            hit_row_q    <= hit_row_d;
            hit_col_q    <= hit_col_d;
            hit_valid_q  <= hit_valid_d;
            wave_clear_q <= wave_clear_d;
        end
    end

`ifdef INVADER_SCORE_EN
    logic [15:0] score_q, score_d;
    logic [16:0] sum;
    logic [4:0]  pts;

    always_comb begin
        unique case (hit_row_q)
            2'd1:    pts = 5'd30;
            2'd2:    pts = 5'd20;
            2'd3:    pts = 5'd10;
            default: pts = 5'd0;
        endcase
        sum     = {1'b0, score_q} + {12'd0, pts};
        score_d = score_q;
        if (state_q == RESP && hit_q && !new_wave)
            score_d = sum[16] ? 16'hFFFF : sum[15:0];
    end

    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) score_q <= '0;
        else        score_q <= score_d;
    end

    assign score = score_q;
`else
    assign score = 16'd0;
`endif

    assign enable_row1 = alive1_q;
    assign enable_row2 = alive2_q;
    assign enable_row3 = alive3_q;
    assign hit_valid   = hit_valid_q;
    assign hit         = hit_q;
    assign hit_row     = hit_row_q;
    assign hit_col     = hit_col_q;
    assign alive_count = count_q;
    assign wave_clear  = wave_clear_q;

endmodule

// File: tb/tb_invader_hit_tracker.sv
// Directed bench for invader_hit_tracker.
// Score checks expect the accumulator only when INVADER_SCORE_EN is defined.
module tb_invader_hit_tracker;

    logic        clk65MHz = 1'b0;
    logic        rst_n;
    logic [9:0]  xpos, ypos;
    logic        bullet_valid;
    logic        bullet_ready;
    logic [10:0] bullet_x, bullet_y;
    logic        new_wave;
    logic [9:0]  enable_row1, enable_row2, enable_row3;
    logic        hit_valid, hit;
    logic [1:0]  hit_row;
    logic [3:0]  hit_col;
    logic [4:0]  alive_count;
    logic        wave_clear;
    logic [15:0] score;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;
    int exp_alive;
    int exp_score;
    int hv_seen;

    invader_hit_tracker dut (
        .clk65MHz     (clk65MHz),
        .rst_n        (rst_n),
        .xpos         (xpos),
        .ypos         (ypos),
        .bullet_valid (bullet_valid),
        .bullet_ready (bullet_ready),
        .bullet_x     (bullet_x),
        .bullet_y     (bullet_y),
        .new_wave     (new_wave),
        .enable_row1  (enable_row1),
        .enable_row2  (enable_row2),
        .enable_row3  (enable_row3),
        .hit_valid    (hit_valid),
        .hit          (hit),
        .hit_row      (hit_row),
        .hit_col      (hit_col),
        .alive_count  (alive_count),
        .wave_clear   (wave_clear),
        .score        (score)
    );

    always #5 clk65MHz = ~clk65MHz;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request, switch grid offset right after acceptance,
    // then count edges until the result strobe (bounded).
    task automatic send(input int bx, input int by,
                        input int nx, input int ny);
        @(negedge clk65MHz);
        bullet_x     = 11'(bx);
        bullet_y     = 11'(by);
        bullet_valid = 1'b1;
        @(posedge clk65MHz);
        #1;
        bullet_valid = 1'b0;
        xpos         = 10'(nx);
        ypos         = 10'(ny);
        lat = 0;
        while (!hit_valid && lat < 30) begin
            @(posedge clk65MHz);
            #1;
            lat++;
        end
    endtask

    function automatic int pts(input int r);
        return (r == 1) ? 30 : (r == 2) ? 20 : 10;
    endfunction

    initial begin
        rst_n        = 1'b0;
        xpos         = '0;
        ypos         = '0;
        bullet_valid = 1'b0;
        bullet_x     = '0;
        bullet_y     = '0;
        new_wave     = 1'b0;
        exp_score    = 0;
        repeat (3) @(posedge clk65MHz);
        #1;
        chk("rst_en1", 32'(enable_row1), 32'h3FF);
        chk("rst_en2", 32'(enable_row2), 32'h3FF);
        chk("rst_en3", 32'(enable_row3), 32'h3FF);
        chk("rst_alive", 32'(alive_count), 32'd30);
        chk("rst_ready", 32'(bullet_ready), 32'd1);
        chk("rst_hv", 32'(hit_valid), 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_wc", 32'(wave_clear), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        @(negedge clk65MHz);
        rst_n = 1'b1;

        send(110, 310, 0, 0);
        chk("k1_lat", 32'(lat), 32'd3);
        chk("k1_hit", 32'(hit), 32'd1);
        chk("k1_row", 32'(hit_row), 32'd3);
        chk("k1_col", 32'(hit_col), 32'd1);
        chk("k1_en3", 32'(enable_row3), 32'h3FD);
        chk("k1_en2", 32'(enable_row2), 32'h3FF);
        chk("k1_alive", 32'(alive_count), 32'd29);
        chk("k1_wc", 32'(wave_clear), 32'd0);
`ifdef INVADER_SCORE_EN
        exp_score = 10;
`endif
        chk("k1_score", 32'(score), 32'(exp_score));
        @(posedge clk65MHz);
        #1;
        chk("k1_hv_pulse", 32'(hit_valid), 32'd0);

        send(110, 310, 0, 0);
        chk("dead_lat", 32'(lat), 32'd11);
        chk("dead_hit", 32'(hit), 32'd0);
        chk("dead_en3", 32'(enable_row3), 32'h3FD);
        chk("dead_alive", 32'(alive_count), 32'd29);

        send(164, 110, 0, 0);
        chk("xedge_lat", 32'(lat), 32'd11);
        chk("xedge_hit", 32'(hit), 32'd0);

        send(163, 131, 0, 0);
        chk("k2_lat", 32'(lat), 32'd3);
        chk("k2_hit", 32'(hit), 32'd1);
        chk("k2_row", 32'(hit_row), 32'd1);
        chk("k2_col", 32'(hit_col), 32'd1);
        chk("k2_en1", 32'(enable_row1), 32'h3FD);
        chk("k2_alive", 32'(alive_count), 32'd28);
`ifdef INVADER_SCORE_EN
        exp_score = 40;
`endif

        exp_alive = 28;
        for (int r = 3; r >= 1; r--) begin
            for (int c = 0; c < 10; c++) begin
                if (c == 1 && (r == 3 || r == 1)) continue;
                send(100 * c + 10,
                     ((r == 1) ? 100 : (r == 2) ? 200 : 300) + 5, 0, 0);
                exp_alive--;
`ifdef INVADER_SCORE_EN
                exp_score += pts(r);
`endif
                chk("ka_lat", 32'(lat), 32'(c + 2));
                chk("ka_row", 32'(hit_row), 32'(r));
                chk("ka_col", 32'(hit_col), 32'(c));
                chk("ka_alive", 32'(alive_count), 32'(exp_alive));
                chk("ka_wc", 32'(wave_clear),
                    (exp_alive == 0) ? 32'd1 : 32'd0);
            end
        end
        chk("clr_en1", 32'(enable_row1), 32'd0);
        chk("clr_en3", 32'(enable_row3), 32'd0);
        chk("clr_score", 32'(score), 32'(exp_score));

        send(510, 205, 0, 0);
        chk("empty_lat", 32'(lat), 32'd11);
        chk("empty_hit", 32'(hit), 32'd0);
        chk("empty_wc", 32'(wave_clear), 32'd0);

        @(negedge clk65MHz);
        new_wave = 1'b1;
        @(negedge clk65MHz);
        new_wave = 1'b0;
        chk("nw_en1", 32'(enable_row1), 32'h3FF);
        chk("nw_en2", 32'(enable_row2), 32'h3FF);
        chk("nw_en3", 32'(enable_row3), 32'h3FF);
        chk("nw_alive", 32'(alive_count), 32'd30);
        chk("nw_score", 32'(score), 32'(exp_score));

        @(negedge clk65MHz);
        bullet_x     = 11'd910;
        bullet_y     = 11'd305;
        bullet_valid = 1'b1;
        @(posedge clk65MHz);
        #1;
        bullet_valid = 1'b0;
        chk("ab_busy", 32'(bullet_ready), 32'd0);
        @(negedge clk65MHz);
        @(negedge clk65MHz);
        new_wave = 1'b1;
        @(posedge clk65MHz);
        #1;
        chk("ab_ready", 32'(bullet_ready), 32'd1);
        @(negedge clk65MHz);
        new_wave = 1'b0;
        hv_seen = 0;
        repeat (15) begin
            @(negedge clk65MHz);
            if (hit_valid) hv_seen++;
        end
        chk("ab_no_hv", 32'(hv_seen), 32'd0);
        chk("ab_en3", 32'(enable_row3), 32'h3FF);
        chk("ab_alive", 32'(alive_count), 32'd30);

        xpos = 10'd50;
        ypos = 10'd20;
        send(200, 230, 0, 0);
        chk("ofs_lat", 32'(lat), 32'd3);
        chk("ofs_row", 32'(hit_row), 32'd2);
        chk("ofs_col", 32'(hit_col), 32'd1);
        chk("ofs_en2", 32'(enable_row2), 32'h3FD);
        chk("ofs_alive", 32'(alive_count), 32'd29);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
